// File: rtl/fsk_pkg.sv
// fsk_pkg: shared types, widths and helper functions for the FSK modulator.
//   state_t            - two-state transmit FSM encoding
//   tx_cfg_t           - per-byte configuration captured at accept
//   default_half_ticks - half-period in clocks of a tone, from clock and tone Hz
//   pick_ticks         - zero-substitution: a zero request selects the default
package fsk_pkg;

  localparam int unsigned TICK_W    = 32;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;
  localparam int unsigned COUNT_W   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Everything a byte needs, frozen at accept so later input changes are ignored
  typedef struct packed {
    logic [TICK_W-1:0] f0_half;
    logic [TICK_W-1:0] f1_half;
    logic [TICK_W-1:0] bit_ticks;
    logic [DATA_W-1:0] data;
  } tx_cfg_t;

  // Half-period of a square wave at tone_hz, rounded down, in clock cycles
  function automatic logic [TICK_W-1:0] default_half_ticks(input int unsigned clk_hz,
                                                           input int unsigned tone_hz);
    return TICK_W'(clk_hz / (2 * tone_hz));
  endfunction

  // A zero request means "use the built-in default"
  function automatic logic [TICK_W-1:0] pick_ticks(input logic [TICK_W-1:0] req,
                                                   input logic [TICK_W-1:0] dflt);
    return (req == '0) ? dflt : req;
  endfunction

endpackage

// File: rtl/fsk_modulator_if.sv
// fsk_modulator_if: transmit bus of the FSK modulator.
//   master - byte source / controller: drives enable, tick settings, tx_data, tx_valid
//   slave  - the modulator: drives tx_ready, sample_out, tx_done, tx_aborted, bytes_sent
interface fsk_modulator_if;
  import fsk_pkg::*;

  logic               enable;
  logic [TICK_W-1:0]  f0_half_ticks;
  logic [TICK_W-1:0]  f1_half_ticks;
  logic [TICK_W-1:0]  bit_ticks;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               sample_out;
  logic               tx_done;
  logic               tx_aborted;
  logic [COUNT_W-1:0] bytes_sent;

  modport master (
    output enable, f0_half_ticks, f1_half_ticks, bit_ticks, tx_data, tx_valid,
    input  tx_ready, sample_out, tx_done, tx_aborted, bytes_sent
  );

  modport slave (
    input  enable, f0_half_ticks, f1_half_ticks, bit_ticks, tx_data, tx_valid,
    output tx_ready, sample_out, tx_done, tx_aborted, bytes_sent
  );

endinterface

// File: rtl/fsk_tone_divider.sv
// fsk_tone_divider: half-period counter for the FSK tone.
//   clock        - rising-edge clock
//   clear        - asynchronous active-low reset
//   half         - active half-period in clocks (1 = toggle every cycle)
//   run          - count this cycle
//   restart      - clear the counter this cycle (byte accept / bit boundary)
//   toggle_pulse - combinational: the output level must flip on this edge
module fsk_tone_divider
  import fsk_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [TICK_W-1:0] half,
  input  logic              run,
  input  logic              restart,
  output logic              toggle_pulse
);

  logic [TICK_W-1:0] half_counter;
  logic              at_end_c;

  assign at_end_c = (half_counter == (half - TICK_W'(1)));

  // Combinational so the toggle lands on the same edge the counter wraps;
  // a restart in that cycle still lets the pending toggle through.
  assign toggle_pulse = run && at_end_c;

  // Half-period counter; restart wins over the normal wrap
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      half_counter <= '0;
    end else if (restart) begin
      half_counter <= '0;
    end else if (run) begin
      if (at_end_c) begin
        half_counter <= '0;
      end else begin
        half_counter <= half_counter + TICK_W'(1);
      end
    end
  end

endmodule

// File: rtl/fsk_modulator.sv
// fsk_modulator: serialises bytes LSB first as a phase-continuous binary FSK
// square wave.
//   clock      - rising-edge clock
//   clear      - asynchronous active-low reset
//   bus        - fsk_modulator_if.slave: enable, tick settings, tx_data/tx_valid in;
//                tx_ready (combinational), sample_out, tx_done, tx_aborted,
//                bytes_sent out
// DEFAULT_FREQUENCY1 must be greater than DEFAULT_FREQUENCY0.
module fsk_modulator
  import fsk_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY    = 50000000,
  parameter int unsigned DEFAULT_FREQUENCY0 = 9000,
  parameter int unsigned DEFAULT_FREQUENCY1 = 11000,
  parameter int unsigned DEFAULT_BIT_TICKS  = 50000
) (
  input  logic           clock,
  input  logic           clear,
  fsk_modulator_if.slave bus
);

  localparam logic [TICK_W-1:0] DFLT_F0_HALF =
    default_half_ticks(CLOCK_FREQUENCY, DEFAULT_FREQUENCY0);
  localparam logic [TICK_W-1:0] DFLT_F1_HALF =
    default_half_ticks(CLOCK_FREQUENCY, DEFAULT_FREQUENCY1);
  localparam logic [TICK_W-1:0] DFLT_BIT_TICKS = TICK_W'(DEFAULT_BIT_TICKS);

  state_t                 state_q;
  state_t                 state_d;
  tx_cfg_t                cfg_q;
  logic [BIT_IDX_W-1:0]   bit_index_q;
  logic [TICK_W-1:0]      bit_counter_q;
  logic                   sample_q;
  logic                   done_q;
  logic                   aborted_q;
  logic [COUNT_W-1:0]     bytes_q;

  logic                   accept_c;
  logic                   run_c;
  logic                   done_c;
  logic                   abort_c;
  logic                   bit_end_c;
  logic                   restart_c;
  logic                   toggle_c;
  logic [TICK_W-1:0]      half_c;

  assign bit_end_c = (bit_counter_q == (cfg_q.bit_ticks - TICK_W'(1)));
  assign half_c    = cfg_q.data[bit_index_q] ? cfg_q.f1_half : cfg_q.f0_half;
  assign restart_c = accept_c || (run_c && bit_end_c);

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle strobes; abort outranks completion
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    run_c    = 1'b0;
    done_c   = 1'b0;
    abort_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable && bus.tx_valid) begin
          accept_c = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (!bus.enable) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end else begin
          run_c = 1'b1;
          if (bit_end_c && (bit_index_q == BIT_IDX_W'(7))) begin
            done_c  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fsk_tone_divider u_tone_divider (
    .clock        (clock),
    .clear        (clear),
    .half         (half_c),
    .run          (run_c),
    .restart      (restart_c),
    .toggle_pulse (toggle_c)
  );

  // Byte capture, bit sequencing, waveform level and statistics
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cfg_q         <= '0;
      bit_index_q   <= '0;
      bit_counter_q <= '0;
      sample_q      <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      bytes_q       <= '0;
    end else begin
      done_q    <= done_c;
      aborted_q <= abort_c;
      if (accept_c) begin
        cfg_q.f0_half   <= pick_ticks(bus.f0_half_ticks, DFLT_F0_HALF);
        cfg_q.f1_half   <= pick_ticks(bus.f1_half_ticks, DFLT_F1_HALF);
        cfg_q.bit_ticks <= pick_ticks(bus.bit_ticks, DFLT_BIT_TICKS);
        cfg_q.data      <= bus.tx_data;
        bit_index_q     <= '0;
        bit_counter_q   <= '0;
      end else if (run_c) begin
        if (bit_end_c) begin
          bit_counter_q <= '0;
          bit_index_q   <= bit_index_q + BIT_IDX_W'(1);
        end else begin
          bit_counter_q <= bit_counter_q + TICK_W'(1);
        end
      end
      // Level is never forced at bit or byte boundaries: phase stays continuous
      if (toggle_c) begin
        sample_q <= ~sample_q;
      end
      if (done_c) begin
        bytes_q <= bytes_q + COUNT_W'(1);
      end
    end
  end

  assign bus.tx_ready   = (state_q == IDLE) && bus.enable;
  assign bus.sample_out = sample_q;
  assign bus.tx_done    = done_q;
  assign bus.tx_aborted = aborted_q;
  assign bus.bytes_sent = bytes_q;

endmodule

// File: tb/tb_fsk_modulator.sv
// tb_fsk_modulator: self-checking bench for fsk_modulator.
// The reference computes the expected level of every SEND cycle directly from
// the byte, the effective half-periods and the bit length with division and
// modulo arithmetic; scaled-down clock parameters keep default-tick runs short.
module tb_fsk_modulator;

  localparam int unsigned TB_CLK = 200000;
  localparam int unsigned TB_F0  = 9000;
  localparam int unsigned TB_F1  = 11000;
  localparam int unsigned TB_BIT = 100;
  localparam int DFLT_F0  = int'(TB_CLK / (2 * TB_F0));
  localparam int DFLT_F1  = int'(TB_CLK / (2 * TB_F1));
  localparam int DFLT_BIT = int'(TB_BIT);

  logic clock = 1'b0;
  logic clear = 1'b0;

  always #5 clock = ~clock;

  fsk_modulator_if bus ();

  fsk_modulator #(
    .CLOCK_FREQUENCY    (TB_CLK),
    .DEFAULT_FREQUENCY0 (TB_F0),
    .DEFAULT_FREQUENCY1 (TB_F1),
    .DEFAULT_BIT_TICKS  (TB_BIT)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic       model_s;
  int         exp_bytes;
  logic [7:0] cur_data;
  int         cur_f0;
  int         cur_f1;
  int         cur_bt;
  int         last_toggles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Present a byte in IDLE, let it be accepted, then scramble the inputs
  task automatic start_byte(input logic [7:0] d, input int f0, input int f1,
                            input int bt, input bit keep_valid);
    bus.tx_data       = d;
    bus.f0_half_ticks = 32'(f0);
    bus.f1_half_ticks = 32'(f1);
    bus.bit_ticks     = 32'(bt);
    bus.tx_valid      = 1'b1;
    check("ready_idle", 32'(bus.tx_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    check("ready_send", 32'(bus.tx_ready), 32'd0);
    check("accept_hold", 32'(bus.sample_out), 32'(model_s));
    cur_data = d;
    cur_f0   = (f0 == 0) ? DFLT_F0 : f0;
    cur_f1   = (f1 == 0) ? DFLT_F1 : f1;
    cur_bt   = (bt == 0) ? DFLT_BIT : bt;
    if (!keep_valid) bus.tx_valid = 1'b0;
    bus.tx_data       = 8'($urandom);
    bus.f0_half_ticks = $urandom_range(1, 15);
    bus.f1_half_ticks = $urandom_range(1, 15);
    bus.bit_ticks     = $urandom_range(1, 50);
  endtask

  // Walk the SEND cycles against the reference; abort_at < 0 means no abort
  task automatic play_byte(input int abort_at);
    int   total;
    int   wave_err;
    int   dut_tog;
    int   mod_tog;
    int   b;
    int   p;
    int   h;
    logic prev;
    total    = 8 * cur_bt;
    wave_err = 0;
    dut_tog  = 0;
    mod_tog  = 0;
    for (int k = 0; k < total; k++) begin
      if (k == abort_at) begin
        bus.enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("wave_before_abort", 32'(wave_err), 32'd0);
        check("abort_pulse", 32'(bus.tx_aborted), 32'd1);
        check("abort_no_done", 32'(bus.tx_done), 32'd0);
        check("abort_hold", 32'(bus.sample_out), 32'(model_s));
        check("abort_bytes", bus.bytes_sent, 32'(exp_bytes));
        check("abort_ready_low", 32'(bus.tx_ready), 32'd0);
        bus.enable = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_one_cycle", 32'(bus.tx_aborted), 32'd0);
        check("abort_idle", 32'(bus.tx_ready), 32'd1);
        check("abort_hold2", 32'(bus.sample_out), 32'(model_s));
        last_toggles = dut_tog;
        return;
      end
      prev = bus.sample_out;
      @(posedge clock);
      @(negedge clock);
      b = k / cur_bt;
      p = k % cur_bt;
      h = cur_data[b] ? cur_f1 : cur_f0;
      if ((p % h) == (h - 1)) begin
        model_s = ~model_s;
        mod_tog++;
      end
      if (bus.sample_out !== prev) dut_tog++;
      if (bus.sample_out !== model_s) wave_err++;
      if (bus.tx_done !== (k == total - 1)) wave_err++;
      if (bus.tx_aborted !== 1'b0) wave_err++;
      if ((k < total - 1) && (bus.tx_ready !== 1'b0)) wave_err++;
    end
    exp_bytes++;
    check("wave", 32'(wave_err), 32'd0);
    check("toggles", 32'(dut_tog), 32'(mod_tog));
    check("done_pulse", 32'(bus.tx_done), 32'd1);
    check("bytes_sent", bus.bytes_sent, 32'(exp_bytes));
    check("ready_after", 32'(bus.tx_ready), 32'd1);
    last_toggles = dut_tog;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("idle_done_low", 32'(bus.tx_done), 32'd0);
    check("idle_hold", 32'(bus.sample_out), 32'(model_s));
    check("idle_bytes", bus.bytes_sent, 32'(exp_bytes));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int d;
    int f0;
    int f1;
    int bt;
    int ab;
    bus.enable        = 1'b1;
    bus.tx_valid      = 1'b0;
    bus.tx_data       = '0;
    bus.f0_half_ticks = '0;
    bus.f1_half_ticks = '0;
    bus.bit_ticks     = '0;
    model_s           = 1'b0;
    exp_bytes         = 0;
    last_toggles      = 0;

    // Reset state
    #12;
    check("rst_sample", 32'(bus.sample_out), 32'd0);
    check("rst_done", 32'(bus.tx_done), 32'd0);
    check("rst_aborted", 32'(bus.tx_aborted), 32'd0);
    check("rst_bytes", bus.bytes_sent, 32'd0);
    check("rst_ready_en1", 32'(bus.tx_ready), 32'd1);
    bus.enable = 1'b0;
    #1;
    check("rst_ready_en0", 32'(bus.tx_ready), 32'd0);
    bus.enable = 1'b1;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);

    // Mixed tones, 0xA5
    start_byte(8'hA5, 4, 3, 24, 1'b0);
    play_byte(-1);
    check("s1_toggles", 32'(last_toggles), 32'd56);
    check("s1_final_level", 32'(bus.sample_out), 32'd0);
    check("s1_bytes", bus.bytes_sent, 32'd1);
    idle_cycles(3);

    // All-zero tick inputs select the defaults
    start_byte(8'h00, 0, 0, 0, 1'b0);
    play_byte(-1);
    check("s2_toggles", 32'(last_toggles), 32'(8 * (DFLT_BIT / DFLT_F0)));
    idle_cycles(2);

    // Abort at SEND cycle 50
    start_byte(8'hA5, 4, 3, 24, 1'b0);
    play_byte(50);
    idle_cycles(2);

    // Back-to-back bytes with tx_valid held
    start_byte(8'h5A, 2, 3, 12, 1'b1);
    play_byte(-1);
    start_byte(8'hC3, 3, 2, 8, 1'b0);
    play_byte(-1);
    idle_cycles(2);

    // Toggle every cycle
    start_byte(8'hFF, 7, 1, 5, 1'b0);
    play_byte(-1);
    check("s6_toggles", 32'(last_toggles), 32'd40);
    idle_cycles(1);

    // Abort in the very last SEND cycle outranks completion
    start_byte(8'h81, 3, 5, 6, 1'b0);
    play_byte(47);
    idle_cycles(1);

    // Random bytes, occasional aborts
    for (int i = 0; i < 14; i++) begin
      d  = int'($urandom_range(0, 255));
      f0 = int'($urandom_range(0, 9));
      f1 = int'($urandom_range(0, 9));
      bt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
      start_byte(8'(d), f0, f1, bt, 1'b0);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8 * cur_bt - 1)) : -1;
      play_byte(ab);
      idle_cycles(int'($urandom_range(1, 3)));
    end

    // Asynchronous reset mid-byte
    start_byte(8'h3C, 5, 2, 10, 1'b0);
    repeat (17) @(posedge clock);
    @(negedge clock);
    #2;
    clear = 1'b0;
    #1;
    check("clr_sample", 32'(bus.sample_out), 32'd0);
    check("clr_done", 32'(bus.tx_done), 32'd0);
    check("clr_aborted", 32'(bus.tx_aborted), 32'd0);
    check("clr_bytes", bus.bytes_sent, 32'd0);
    check("clr_ready", 32'(bus.tx_ready), 32'd1);
    repeat (3) begin
      @(negedge clock);
      check("clr_no_done", 32'(bus.tx_done), 32'd0);
      check("clr_no_abort", 32'(bus.tx_aborted), 32'd0);
    end
    clear     = 1'b1;
    model_s   = 1'b0;
    exp_bytes = 0;
    @(negedge clock);
    check("clr_no_pulse_after", 32'(bus.tx_done | bus.tx_aborted), 32'd0);
    start_byte(8'h96, 3, 4, 9, 1'b0);
    play_byte(-1);
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fsk_modulator.md
FSK_MODULATOR -- requirements
Module: fsk_modulator

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 50000000, is the clock rate in Hz.
REQ-002 Parameter DEFAULT_FREQUENCY0, default 9000, is the tone for bit 0 in Hz.
REQ-003 Parameter DEFAULT_FREQUENCY1, default 11000, is the tone for bit 1 in Hz; it SHALL always be greater than DEFAULT_FREQUENCY0.
REQ-004 Parameter DEFAULT_BIT_TICKS, default 50000, is the bit duration in clocks.
REQ-005 One clock and one reset: reset is asynchronous and active-low.
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 clear  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  run permission; low aborts any byte in progress.
REQ-009 f0_half_ticks  in  32  half-period of tone 0 in clocks; 0 selects CLOCK_FREQUENCY/(2*DEFAULT_FREQUENCY0).
REQ-010 f1_half_ticks  in  32  half-period of tone 1 in clocks; 0 selects CLOCK_FREQUENCY/(2*DEFAULT_FREQUENCY1).
REQ-011 bit_ticks  in  32  bit duration in clocks; 0 selects DEFAULT_BIT_TICKS.
REQ-012 tx_data  in  8  byte to send, LSB first.
REQ-013 tx_valid  in  1  tx_data is valid.
REQ-014 tx_ready  out  1  block can accept a byte.
REQ-015 sample_out  out  1  FSK square-wave output.
REQ-016 tx_done  out  1  one-cycle pulse when a byte completes normally.
REQ-017 tx_aborted  out  1  one-cycle pulse when a byte is cut short by enable low.
REQ-018 bytes_sent  out  32  count of completed bytes, wraps modulo 2^32.

Function
REQ-019 The state machine SHALL have two states: IDLE and SEND.
REQ-020 tx_ready SHALL be combinational: high only when state is IDLE and enable is high.
REQ-021 A byte SHALL be accepted on a rising edge where tx_valid and tx_ready are both high.
REQ-022 On accept, the block SHALL latch tx_data and the effective f0/f1 half-ticks and bit_ticks (after zero substitution), clear bit_index, bit_counter and half_counter, and enter SEND on the next cycle.
REQ-023 Input changes on tick inputs during SEND SHALL have no effect until the next accept.
REQ-024 In SEND, the active half-period SHALL be f1 when the current bit is 1 and f0 when it is 0.
REQ-025 Each SEND cycle, half_counter SHALL increment; when it equals half-1, sample_out SHALL toggle and half_counter SHALL clear; half=1 means toggle every cycle.
REQ-026 Each SEND cycle, bit_counter SHALL increment; when it equals bit_ticks-1, bit_counter and half_counter SHALL clear and bit_index SHALL advance.
REQ-027 A toggle and a bit boundary in the same cycle SHALL both take effect, so the waveform stays phase-continuous.
REQ-028 sample_out SHALL NOT be forced to any level at a bit boundary or at the end of a byte.
REQ-029 At the bit boundary with bit_index==7, the FSM SHALL return to IDLE, pulse tx_done for one cycle, and increment bytes_sent.
REQ-030 A byte SHALL occupy exactly 8*bit_ticks SEND cycles; at least one IDLE cycle SHALL occur between bytes, so tx_ready cannot be high in any SEND cycle.
REQ-031 sample_out SHALL hold its level in IDLE.
REQ-032 If enable is low during SEND, the FSM SHALL enter IDLE next cycle and pulse tx_aborted; tx_done and bytes_sent SHALL NOT change.
REQ-033 If enable is low in the last SEND cycle, abort SHALL take priority over completion.
REQ-034 All counters SHALL be 32-bit unsigned; bit_index SHALL be 3-bit.

Reset
REQ-035 While clear is low, the block SHALL force state=IDLE, sample_out=0, tx_done=0, tx_aborted=0, bytes_sent=0, clear all counters, and clear latched data.
REQ-036 Reset asserted mid-byte SHALL discard the byte without a tx_done or tx_aborted pulse.
REQ-037 After clear is released, tx_ready SHALL equal enable.

Structure
REQ-038 Package fsk_pkg SHALL hold the state enumeration, the default-tick constant functions, and the zero-substitution helper.
REQ-039 Sub-module fsk_tone_divider SHALL contain the half_counter and toggle logic, with inputs half, run and restart and output toggle_pulse.
REQ-040 fsk_modulator SHALL contain the FSM, bit sequencing and statistics.

Verification
REQ-041 Scenario 1: f0_half=4, f1_half=3, bit_ticks=24, tx_data=0xA5 -> 56 toggles, tx_done 192 cycles after SEND entry, sample_out ends at 0, bytes_sent=1.
REQ-042 Scenario 2: all tick inputs 0 at defaults, tx_data=0x00 -> toggles every 2777 cycles, byte lasts 400000 cycles.
REQ-043 Scenario 3: enable dropped at SEND cycle 50 of Scenario 1 -> tx_aborted pulse, IDLE, bytes_sent=0, sample_out holds.
REQ-044 Scenario 4: tx_valid held high for two bytes -> second accept one IDLE cycle after tx_done, with no sample_out glitch.
REQ-045 Scenario 5: clear asserted mid-byte -> all outputs at reset values immediately (asynchronous), with no done or abort pulse.
REQ-046 Scenario 6: f1_half=1, bit_ticks=5, tx_data=0xFF -> sample_out toggles every cycle, 40 toggles total.
